// File: rtl/mbist_pkg.sv
// March C- BIST shared types and element table.
// FSM states, element indices and per-element op constants.
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FINISH
    } state_e;

    typedef enum logic [2:0] {
        E0 = 3'd0,
        E1 = 3'd1,
        E2 = 3'd2,
        E3 = 3'd3,
        E4 = 3'd4,
        E5 = 3'd5
    } elem_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Address direction of an element.
    function automatic logic elem_dir(input elem_e e);
        return (e == E3 || e == E4) ? DIR_DOWN : DIR_UP;
    endfunction

    // Ops per address: E0/E5 have one, the rest read-then-write.
    function automatic logic [1:0] elem_nops(input elem_e e);
        return (e == E0 || e == E5) ? 2'd1 : 2'd2;
    endfunction

    // Background bit expected by the element's read.
    function automatic logic elem_rval(input elem_e e);
        return (e == E2 || e == E4) ? 1'b1 : 1'b0;
    endfunction

    // Background bit written by the element's write.
    function automatic logic elem_wval(input elem_e e);
        return (e == E1 || e == E3) ? 1'b1 : 1'b0;
    endfunction

    // Operation for a given phase of an element.
    function automatic logic elem_op(input elem_e e,
                                     input logic  phase);
        if (elem_nops(e) == 2'd1)
            return (e == E0) ? OP_WRITE : OP_READ;
        return phase ? OP_WRITE : OP_READ;
    endfunction

    // Element that follows e in the sequence.
    function automatic elem_e elem_next(input elem_e e);
        elem_e n;
        unique case (e)
            E0:      n = E1;
            E1:      n = E2;
            E2:      n = E3;
            E3:      n = E4;
            E4:      n = E5;
            default: n = E0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mbist_march_seq.sv
// March C- op generator (S0).
// Walks elements, addresses and read/write phases one op per clock.
module mbist_march_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  launch,
    output logic                  op_valid,
    output logic                  op,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last_op
);
    import mbist_pkg::*;

    localparam int LAST_I = CAPACITY - 1;
    localparam logic [ADDR_WIDTH:0] LAST_ADDR  = LAST_I[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] FIRST_ADDR = '0;
    localparam logic [ADDR_WIDTH:0] ONE_ADDR   = 1;

    logic                valid_q;
    elem_e               elem_q;
    logic [ADDR_WIDTH:0] addr_q;
    logic                phase_q;

    logic  at_end_addr;
    logic  phase_done;
    logic  cur_op;
    logic  cur_val;
    elem_e nxt_elem;

    // Decode the current op and detect element/sequence ends.
    always_comb begin
        at_end_addr = 1'b0;
        if (elem_dir(elem_q) == DIR_UP)
            at_end_addr = (addr_q == LAST_ADDR);
        else
            at_end_addr = (addr_q == FIRST_ADDR);
        phase_done = (elem_nops(elem_q) == 2'd1) || phase_q;
        cur_op     = elem_op(elem_q, phase_q);
        cur_val    = (cur_op == OP_WRITE) ? elem_wval(elem_q)
                                          : elem_rval(elem_q);
        nxt_elem   = elem_next(elem_q);
        last_op    = valid_q && (elem_q == E5)
                     && at_end_addr && phase_done;
    end

    assign op_valid = valid_q;
    assign op       = valid_q ? cur_op : OP_READ;
    assign addr     = addr_q[ADDR_WIDTH-1:0];
    assign data     = valid_q ? {DATA_WIDTH{cur_val}} : '0;

    // Advance phase, then address, then element; stop after E5.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            elem_q  <= E0;
            addr_q  <= FIRST_ADDR;
            phase_q <= 1'b0;
        end else if (launch) begin
            valid_q <= 1'b1;
            elem_q  <= E0;
            addr_q  <= FIRST_ADDR;
            phase_q <= 1'b0;
        end else if (valid_q) begin
            if (last_op) begin
                valid_q <= 1'b0;
                phase_q <= 1'b0;
            end else if (!phase_done) begin
                phase_q <= 1'b1;
            end else begin
                phase_q <= 1'b0;
                if (at_end_addr) begin
                    elem_q <= nxt_elem;
                    if (elem_dir(nxt_elem) == DIR_UP)
                        addr_q <= FIRST_ADDR;
                    else
                        addr_q <= LAST_ADDR;
                end else if (elem_dir(elem_q) == DIR_UP) begin
                    addr_q <= addr_q + ONE_ADDR;
                end else begin
                    addr_q <= addr_q - ONE_ADDR;
                end
            end
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller.
// FSM, bus stage S1, read-compare pipeline and result registers.
module mbist_march_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int CAPACITY      = 16,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     write_read,
    output logic [ADDR_WIDTH-1:0]    address,
    output logic [DATA_WIDTH-1:0]    wdata,
    input  logic [DATA_WIDTH-1:0]    rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ADDR_WIDTH-1:0]    fail_addr,
    output logic [DATA_WIDTH-1:0]    fail_mask,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);
    import mbist_pkg::*;

    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = 1;

    state_e state_q;
    state_e state_d;
    logic   accept;
    logic   busy_c;
    logic   done_c;
    logic   fin_edge;

    logic                  s0_valid;
    logic                  s0_op;
    logic [ADDR_WIDTH-1:0] s0_addr;
    logic [DATA_WIDTH-1:0] s0_data;
    logic                  s0_last;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_exp;

    logic                  c1_valid;
    logic [ADDR_WIDTH-1:0] c1_addr;
    logic [DATA_WIDTH-1:0] c1_exp;
    logic                  c2_valid;
    logic [ADDR_WIDTH-1:0] c2_addr;
    logic [DATA_WIDTH-1:0] c2_exp;

    logic                     mism;
    logic [ERR_CNT_WIDTH-1:0] err_nxt;

    mbist_march_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CAPACITY   (CAPACITY)
    ) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .launch   (accept),
        .op_valid (s0_valid),
        .op       (s0_op),
        .addr     (s0_addr),
        .data     (s0_data),
        .last_op  (s0_last)
    );

    // wdata leads its write op by one cycle to match the memory.
    assign wdata = s0_data;
    assign busy  = busy_c;
    assign done  = done_c;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state and status outputs.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy_c  = 1'b1;
        done_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (s0_last)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!s1_valid && !c1_valid)
                    state_d = ST_FINISH;
            end
            ST_FINISH: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // S1: present the op on the bus; idle cycles read, address holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            write_read <= OP_READ;
            address    <= '0;
            s1_exp     <= '0;
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                write_read <= s0_op;
                address    <= s0_addr;
                s1_exp     <= s0_data;
            end else begin
                write_read <= OP_READ;
            end
        end
    end

    // Two-deep expected-value pipeline covering the read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1_valid <= 1'b0;
            c1_addr  <= '0;
            c1_exp   <= '0;
            c2_valid <= 1'b0;
            c2_addr  <= '0;
            c2_exp   <= '0;
        end else begin
            c1_valid <= s1_valid && (write_read == OP_READ);
            c1_addr  <= address;
            c1_exp   <= s1_exp;
            c2_valid <= c1_valid;
            c2_addr  <= c1_addr;
            c2_exp   <= c1_exp;
        end
    end

    // Compare and saturating error count.
    always_comb begin
        mism    = c2_valid && (rdata != c2_exp);
        err_nxt = err_cnt;
        if (mism && (err_cnt != ERR_MAX))
            err_nxt = err_cnt + ERR_ONE;
        fin_edge = (state_q == ST_DRAIN) && (state_d == ST_FINISH);
    end

    // Results: cleared on start, first mismatch captured, pass at end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
        end else if (accept) begin
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
        end else begin
            err_cnt <= err_nxt;
            if (mism && (err_cnt == '0)) begin
                fail_addr <= c2_addr;
                fail_mask <= rdata ^ c2_exp;
            end
            if (fin_edge)
                pass <= (err_nxt == '0);
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Self-checking bench for mbist_march_ctrl.
// Fault memory model plus an element-level March C- reference.
module tb_mbist_march_ctrl;

    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int CAP  = 16;
    localparam int EW   = 8;
    localparam int NOPS = 10 * CAP;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          write_read;
    logic [AW-1:0] address;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_mask;
    logic [EW-1:0] err_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // fault configuration
    bit            sa_en;
    int            sa_addr;
    logic [DW-1:0] sa_mask;
    bit            sa_val;
    bit            cf_en;
    int            cf_addr;
    logic [DW-1:0] cf_mask;

    // memory model
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] wq;
    logic [DW-1:0] r1;

    // reference results
    logic          exp_wr [NOPS];
    logic [AW-1:0] exp_ad [NOPS];
    logic [DW-1:0] exp_wd [NOPS];
    int            ref_err;
    logic [AW-1:0] ref_faddr;
    logic [DW-1:0] ref_fmask;

    // bus trace, indexed by edge number after start
    logic          rec_wr   [512];
    logic [AW-1:0] rec_ad   [512];
    logic [DW-1:0] rec_wd   [512];
    logic          rec_busy [512];

    // March C- element table
    int e_down [6] = '{0, 0, 0, 1, 1, 0};
    int e_n    [6] = '{1, 2, 2, 2, 2, 1};
    bit e_op0  [6] = '{1, 0, 0, 0, 0, 0};
    bit e_v0   [6] = '{0, 0, 1, 0, 1, 0};
    bit e_v1   [6] = '{0, 1, 0, 1, 0, 0};

    mbist_march_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .CAPACITY      (CAP),
        .ERR_CNT_WIDTH (EW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .write_read (write_read),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .fail_mask  (fail_mask),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] sa_apply(int a, logic [DW-1:0] v);
        if (sa_en && a == sa_addr)
            return sa_val ? (v | sa_mask) : (v & ~sa_mask);
        return v;
    endfunction

    function automatic logic [DW-1:0] cf_apply(int a, logic [DW-1:0] old,
                                               logic [DW-1:0] nw,
                                               logic [DW-1:0] nb);
        if (cf_en && a == cf_addr && nb == 8'hFF)
            return (nw & ~cf_mask) | (old & cf_mask);
        return nw;
    endfunction

    // memory: wdata registered one cycle, 2-cycle read latency
    always @(posedge clk) begin
        wq <= wdata;
        if (write_read)
            mem[address] <= cf_apply(int'(address), mem[address], wq,
                                     mem[address - 4'd1]);
        r1    <= sa_apply(int'(address), mem[address]);
        rdata <= r1;
    end

    task automatic clear_faults();
        sa_en   = 0;
        sa_addr = 0;
        sa_mask = '0;
        sa_val  = 0;
        cf_en   = 0;
        cf_addr = 1;
        cf_mask = '0;
    endtask

    // Element-level March C- over an array with the same fault rules.
    task automatic ref_march();
        logic [DW-1:0] rm [CAP];
        logic [DW-1:0] word;
        logic [DW-1:0] got;
        logic [DW-1:0] nb;
        int k, a;
        bit isw, v;
        k = 0;
        ref_err = 0;
        ref_faddr = '0;
        ref_fmask = '0;
        for (int i = 0; i < CAP; i++) rm[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < CAP; i++) begin
                a = e_down[e] ? CAP - 1 - i : i;
                for (int p = 0; p < e_n[e]; p++) begin
                    isw  = (p == 0) ? e_op0[e] : 1'b1;
                    v    = (p == 0) ? e_v0[e] : e_v1[e];
                    word = v ? 8'hFF : 8'h00;
                    exp_wr[k] = isw;
                    exp_ad[k] = AW'(a);
                    exp_wd[k] = word;
                    k++;
                    if (isw) begin
                        nb = (a > 0) ? rm[a-1] : rm[CAP-1];
                        rm[a] = cf_apply(a, rm[a], word, nb);
                    end else begin
                        got = sa_apply(a, rm[a]);
                        if (got != word) begin
                            if (ref_err == 0) begin
                                ref_faddr = AW'(a);
                                ref_fmask = got ^ word;
                            end
                            if (ref_err < 255) ref_err++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic record(int n);
        rec_wr[n]   = write_read;
        rec_ad[n]   = address;
        rec_wd[n]   = wdata;
        rec_busy[n] = busy;
    endtask

    // Start a run (unless already accepted) and trace until done.
    task automatic run_march(input int extra_n, input bit pre_started,
                             output int done_n);
        int n;
        done_n = -1;
        if (!pre_started) begin
            @(posedge clk); #1 start = 1;
            @(posedge clk); #1 start = 0;
        end
        n = 0;
        record(0);
        while (n < 400 && done_n < 0) begin
            start = (n == extra_n);
            @(posedge clk); #1;
            n++;
            record(n);
            if (done) done_n = n;
        end
        start = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        start = 0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({write_read, address, wdata, busy, done, pass,
             fail_addr, fail_mask, err_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0",
                     {write_read, address, wdata, busy, done, pass,
                      fail_addr, fail_mask, err_cnt});
        end
        rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b done=%b want 0 0",
                     busy, done);
        end
    endtask

    task automatic test_fault_free();
        int dn, nw, nb, bad;
        clear_faults();
        ref_march();
        run_march(-1, 0, dn);
        vectors++;
        if (dn !== NOPS + 3) begin
            miscompares++;
            $display("FAIL ff_done_edge: got %0d want %0d", dn, NOPS + 3);
        end
        vectors++;
        if (pass !== 1'b1 || err_cnt !== 0 || fail_mask !== 8'h00) begin
            miscompares++;
            $display("FAIL ff_result: pass=%b err=%0d mask=%h want 1 0 00",
                     pass, err_cnt, fail_mask);
        end
        bad = 0;
        for (int j = 0; j < NOPS; j++) begin
            vectors++;
            if (rec_wr[j+1] !== exp_wr[j] || rec_ad[j+1] !== exp_ad[j] ||
                (exp_wr[j] && rec_wd[j] !== exp_wd[j])) begin
                miscompares++;
                if (bad < 4)
                    $display("FAIL ff_bus_op%0d: wr=%b ad=%0d wd=%h want %b %0d %h",
                             j, rec_wr[j+1], rec_ad[j+1], rec_wd[j],
                             exp_wr[j], exp_ad[j], exp_wd[j]);
                bad++;
            end
        end
        vectors++;
        if (rec_wr[81] !== 1'b0 || rec_ad[81] !== 4'd15 || rec_wd[80] !== 8'h00) begin
            miscompares++;
            $display("FAIL ff_e3_first: wr=%b ad=%0d exp=%h want 0 15 00",
                     rec_wr[81], rec_ad[81], rec_wd[80]);
        end
        nw = 0;
        nb = 0;
        for (int j = 0; j <= NOPS + 3; j++) begin
            if (rec_wr[j] === 1'b1) nw++;
            if (rec_busy[j] === 1'b1) nb++;
        end
        vectors++;
        if (nw != NOPS / 2 || rec_wr[NOPS+1] !== 1'b0) begin
            miscompares++;
            $display("FAIL ff_write_count: got %0d want %0d", nw, NOPS / 2);
        end
        vectors++;
        if (nb != NOPS + 4) begin
            miscompares++;
            $display("FAIL ff_busy_span: got %0d want %0d", nb, NOPS + 4);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b1) begin
            miscompares++;
            $display("FAIL ff_after_done: busy=%b done=%b pass=%b want 0 0 1",
                     busy, done, pass);
        end
    endtask

    task automatic test_stuck_at();
        int dn;
        clear_faults();
        sa_en = 1; sa_addr = 6; sa_mask = 8'h20; sa_val = 1;
        ref_march();
        run_march(-1, 0, dn);
        vectors++;
        if (fail_addr !== 4'd6 || fail_mask !== 8'h20 ||
            err_cnt !== 8'd3 || pass !== 1'b0) begin
            miscompares++;
            $display("FAIL sa_result: addr=%0d mask=%h err=%0d pass=%b want 6 20 3 0",
                     fail_addr, fail_mask, err_cnt, pass);
        end
        vectors++;
        if (err_cnt !== EW'(ref_err) || fail_addr !== ref_faddr ||
            dn !== NOPS + 3) begin
            miscompares++;
            $display("FAIL sa_model: err=%0d addr=%0d dn=%0d want %0d %0d %0d",
                     err_cnt, fail_addr, dn, ref_err, ref_faddr, NOPS + 3);
        end
    endtask

    task automatic test_coupling();
        int dn;
        clear_faults();
        cf_en = 1; cf_addr = 6; cf_mask = 8'h20;
        ref_march();
        run_march(-1, 0, dn);
        vectors++;
        if (fail_addr !== 4'd6 || fail_mask !== 8'h20 || pass !== 1'b0) begin
            miscompares++;
            $display("FAIL cf_result: addr=%0d mask=%h pass=%b want 6 20 0",
                     fail_addr, fail_mask, pass);
        end
        vectors++;
        if (err_cnt !== EW'(ref_err)) begin
            miscompares++;
            $display("FAIL cf_err_cnt: got %0d want %0d", err_cnt, ref_err);
        end
    endtask

    task automatic test_start_while_busy();
        int dn;
        clear_faults();
        run_march(20, 0, dn);
        vectors++;
        if (dn !== NOPS + 3 || pass !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_start: dn=%0d pass=%b want %0d 1",
                     dn, pass, NOPS + 3);
        end
    endtask

    task automatic test_back_to_back();
        int dn;
        clear_faults();
        sa_en = 1; sa_addr = 6; sa_mask = 8'h20; sa_val = 1;
        run_march(-1, 0, dn);
        start = 1;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || pass !== 1'b0 || err_cnt !== 8'd3) begin
            miscompares++;
            $display("FAIL b2b_finish_start: busy=%b pass=%b err=%0d want 0 0 3",
                     busy, pass, err_cnt);
        end
        sa_en = 0;
        @(posedge clk); #1 start = 0;
        vectors++;
        if (busy !== 1'b1 || err_cnt !== 0 || fail_addr !== 0 ||
            fail_mask !== 0 || pass !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_clear: busy=%b err=%0d addr=%0d mask=%h pass=%b want 1 0 0 00 0",
                     busy, err_cnt, fail_addr, fail_mask, pass);
        end
        run_march(-1, 1, dn);
        vectors++;
        if (dn !== NOPS + 3 || pass !== 1'b1 || err_cnt !== 0) begin
            miscompares++;
            $display("FAIL b2b_second: dn=%0d pass=%b err=%0d want %0d 1 0",
                     dn, pass, err_cnt, NOPS + 3);
        end
    endtask

    task automatic test_abort();
        int n, nd, nb, dn;
        clear_faults();
        sa_en = 1; sa_addr = 6; sa_mask = 8'h20; sa_val = 1;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        n = 0;
        while (n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (err_cnt !== 8'd1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pre: err=%0d busy=%b want 1 1", err_cnt, busy);
        end
        #2 rst_n = 0;
        #1;
        vectors++;
        if ({write_read, address, wdata, busy, done, pass,
             fail_addr, fail_mask, err_cnt} !== '0) begin
            miscompares++;
            $display("FAIL abort_outputs: got %h want 0",
                     {write_read, address, wdata, busy, done, pass,
                      fail_addr, fail_mask, err_cnt});
        end
        @(posedge clk); #1 rst_n = 1;
        nd = 0;
        nb = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (done === 1'b1) nd++;
            if (busy === 1'b1) nb++;
        end
        vectors++;
        if (nd != 0 || nb != 0) begin
            miscompares++;
            $display("FAIL abort_no_done: done=%0d busy=%0d want 0 0", nd, nb);
        end
        sa_en = 0;
        run_march(-1, 0, dn);
        vectors++;
        if (dn !== NOPS + 3 || pass !== 1'b1 || err_cnt !== 0) begin
            miscompares++;
            $display("FAIL abort_rerun: dn=%0d pass=%b err=%0d want %0d 1 0",
                     dn, pass, err_cnt, NOPS + 3);
        end
    endtask

    task automatic test_random_faults();
        int dn;
        repeat (4) begin
            clear_faults();
            sa_en   = 1;
            sa_addr = $urandom_range(0, CAP - 1);
            sa_mask = 8'h01 << $urandom_range(0, DW - 1);
            sa_val  = 1'($urandom_range(0, 1));
            ref_march();
            repeat ($urandom_range(0, 5)) @(posedge clk);
            run_march(-1, 0, dn);
            vectors++;
            if (dn !== NOPS + 3 || pass !== (ref_err == 0) ||
                err_cnt !== EW'(ref_err) || fail_addr !== ref_faddr ||
                fail_mask !== ref_fmask) begin
                miscompares++;
                $display("FAIL rnd_sa a%0d m%h v%0d: dn=%0d pass=%b err=%0d addr=%0d mask=%h want err=%0d addr=%0d mask=%h",
                         sa_addr, sa_mask, sa_val, dn, pass, err_cnt,
                         fail_addr, fail_mask, ref_err, ref_faddr, ref_fmask);
            end
        end
    endtask

    initial begin
        clear_faults();
        rst_n = 0;
        start = 0;
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
        test_reset();
        test_fault_free();
        test_stuck_at();
        test_coupling();
        test_start_while_busy();
        test_back_to_back();
        test_abort();
        test_random_faults();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
